// File: rtl/vga_rect_engine_if.sv
// Configuration and video-out bundle for vga_rect_engine.
// master: the side that sets geometry/mode and consumes the video signals.
// slave:  the engine itself.
interface vga_rect_engine_if #(
  parameter int HCW     = 10,
  parameter int VCW     = 10,
  parameter int COLOR_W = 3
);
  logic [HCW-1:0]       width;
  logic [VCW-1:0]       height;
  logic [3*COLOR_W-1:0] fg_rgb;
  logic                 rev;
  logic                 fl;
  logic                 test_mode;

  logic                 h_sync;
  logic                 v_sync;
  logic [COLOR_W-1:0]   red;
  logic [COLOR_W-1:0]   green;
  logic [COLOR_W-1:0]   blue;
  logic                 visible;
  logic                 frame_start;

  modport master (
    output width, height, fg_rgb, rev, fl, test_mode,
    input  h_sync, v_sync, red, green, blue, visible, frame_start
  );

  modport slave (
    input  width, height, fg_rgb, rev, fl, test_mode,
    output h_sync, v_sync, red, green, blue, visible, frame_start
  );
endinterface

// File: rtl/vga_rect_engine.sv
// vga_rect_engine: VGA timing generator that draws a centred bordered
// rectangle. Geometry/mode inputs are shadowed at h=0,v=0 so a frame never
// tears; every output is registered one cycle after its counter value.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN.
module vga_rect_engine #(
  parameter int H_PIXELS     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ROWS       = 400,
  parameter int V_FP         = 12,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 35,
  parameter int H_SYNC_POL   = 0,
  parameter int V_SYNC_POL   = 1,
  parameter int HCW          = 10,
  parameter int VCW          = 10,
  parameter int COLOR_W      = 3,
  parameter int BORDER       = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             pulse25M,
  input  logic             reset,
  vga_rect_engine_if.slave vif
);
  localparam int H_NV    = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_NV + H_PIXELS;
  localparam int V_NV    = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_NV + V_ROWS;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_NV_C = HCW'(H_NV);
  localparam logic [HCW-1:0] HS_BEG = HCW'(H_FP);
  localparam logic [HCW-1:0] HS_END = HCW'(H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_NV_C = VCW'(V_NV);
  localparam logic [VCW-1:0] VS_BEG = VCW'(V_FP);
  localparam logic [VCW-1:0] VS_END = VCW'(V_FP + V_SYNC);

  localparam logic HS_ON = 1'(H_SYNC_POL);
  localparam logic VS_ON = 1'(V_SYNC_POL);

  // Box geometry is evaluated in 32 bits using additions only, so the grown
  // box may extend past the left/top edge without any signed arithmetic.
  localparam logic [31:0] H_NV32 = 32'(H_NV);
  localparam logic [31:0] V_NV32 = 32'(V_NV);
  localparam logic [31:0] MAX_W  = 32'(H_PIXELS);
  localparam logic [31:0] MAX_H  = 32'(V_ROWS);
  localparam logic [31:0] MID_X  = 32'(H_PIXELS / 2);
  localparam logic [31:0] MID_Y  = 32'(V_ROWS / 2);
  localparam logic [31:0] BRD    = 32'(BORDER);

  localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BFW-1:0] BF_LAST = BFW'(BLINK_FRAMES - 1);

  logic [HCW-1:0]       h_cnt;
  logic [VCW-1:0]       v_cnt;
  logic                 frame_tick;
  logic                 frame_end;

  logic [HCW-1:0]       w_s;
  logic [VCW-1:0]       h_s;
  logic [3*COLOR_W-1:0] fg_s;
  logic                 rev_s;
  logic                 fl_s;

  logic [BFW-1:0]       blink_cnt;
  logic                 phase;
  logic                 flash;

  logic [31:0]          x, y;
  logic [31:0]          w_clamp, h_clamp;
  logic [31:0]          half_w, half_h;
  logic                 vis_c, hs_c, vs_c;
  logic                 in_box, in_grow, border_c;
  logic [COLOR_W-1:0]   mask_r, mask_f;
  logic [COLOR_W-1:0]   r_c, g_c, b_c;

  logic                 hs_q, vs_q, vis_q, fs_q;
  logic [COLOR_W-1:0]   r_q, g_q, b_q;

  assign frame_tick = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge pulse25M) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Per-frame shadow of geometry and mode inputs.
  always_ff @(posedge pulse25M) begin
    if (!reset) begin
      w_s   <= '0;
      h_s   <= '0;
      fg_s  <= '0;
      rev_s <= 1'b0;
      fl_s  <= 1'b0;
    end else if (frame_tick) begin
      w_s   <= vif.width;
      h_s   <= vif.height;
      fg_s  <= vif.fg_rgb;
      rev_s <= vif.rev;
      fl_s  <= vif.fl;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic        tm_s;
  logic [31:0] bar_idx;
  logic [2:0]  bar;

  // Test-mode shadow, latched alongside the other frame inputs.
  always_ff @(posedge pulse25M) begin
    if (!reset) begin
      tm_s <= 1'b0;
    end else if (frame_tick) begin
      tm_s <= vif.test_mode;
    end
  end

  assign bar_idx = x / 32'(H_PIXELS / 8);
  assign bar     = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
`else
  logic unused_test_mode;
  assign unused_test_mode = vif.test_mode;
`endif

  // Blink timebase: counts completed frames, so the first frame after reset
  // gets a full half-period; the phase flips at the last pixel of a frame.
  always_ff @(posedge pulse25M) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BF_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign flash  = fl_s & phase;
  assign mask_r = {COLOR_W{rev_s}};
  assign mask_f = {COLOR_W{flash}};

  assign hs_c  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_c  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign vis_c = (h_cnt >= H_NV_C) && (v_cnt >= V_NV_C);

  // x/y are only meaningful while vis_c is high.
  assign x       = 32'(h_cnt) - H_NV32;
  assign y       = 32'(v_cnt) - V_NV32;
  assign w_clamp = (32'(w_s) > MAX_W) ? MAX_W : 32'(w_s);
  assign h_clamp = (32'(h_s) > MAX_H) ? MAX_H : 32'(h_s);
  assign half_w  = w_clamp >> 1;
  assign half_h  = h_clamp >> 1;

  assign in_box  = (x + half_w >= MID_X) && (x < MID_X + half_w) &&
                   (y + half_h >= MID_Y) && (y < MID_Y + half_h);
  assign in_grow = (x + half_w + BRD >= MID_X) && (x < MID_X + half_w + BRD) &&
                   (y + half_h + BRD >= MID_Y) && (y < MID_Y + half_h + BRD);
  assign border_c = vis_c && (w_clamp != '0) && (h_clamp != '0) && in_grow && !in_box;

  // Pixel colour: blank outside the active area, border or background inside.
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (vis_c) begin
`ifdef VGA_TEST_PATTERN_EN
      if (tm_s) begin
        r_c = {COLOR_W{bar[2]}} ^ mask_r;
        g_c = {COLOR_W{bar[1]}} ^ mask_r;
        b_c = {COLOR_W{bar[0]}} ^ mask_r;
      end else
`endif
      if (border_c) begin
        r_c = fg_s[3*COLOR_W-1:2*COLOR_W] ^ mask_r ^ mask_f;
        g_c = fg_s[2*COLOR_W-1:COLOR_W]   ^ mask_r ^ mask_f;
        b_c = fg_s[COLOR_W-1:0]           ^ mask_r ^ mask_f;
      end else begin
        r_c = mask_r;
        g_c = mask_r;
        b_c = mask_r;
      end
    end
  end

  // Output register stage keeps sync, visible and colour aligned.
  always_ff @(posedge pulse25M) begin
    if (!reset) begin
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      vis_q <= 1'b0;
      fs_q  <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      hs_q  <= hs_c ? HS_ON : ~HS_ON;
      vs_q  <= vs_c ? VS_ON : ~VS_ON;
      vis_q <= vis_c;
      fs_q  <= frame_tick;
      r_q   <= r_c;
      g_q   <= g_c;
      b_q   <= b_c;
    end
  end

  assign vif.h_sync      = hs_q;
  assign vif.v_sync      = vs_q;
  assign vif.visible     = vis_q;
  assign vif.frame_start = fs_q;
  assign vif.red         = r_q;
  assign vif.green       = g_q;
  assign vif.blue        = b_q;
endmodule

// File: tb/tb_vga_rect_engine.sv
// Bench for vga_rect_engine on a shrunken raster (40x20 total, 32x16 active)
// so that many frames fit in a short run. Outputs are packed as
// {frame_start, h_sync, v_sync, visible, red, green, blue}.
module tb_vga_rect_engine;
  localparam int HCW     = 6;
  localparam int VCW     = 5;
  localparam int CW      = 2;
  localparam int H_TOTAL = 40;
  localparam int FRAME   = 800;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   pos   = 0;

  vga_rect_engine_if #(.HCW(HCW), .VCW(VCW), .COLOR_W(CW)) vif ();

  vga_rect_engine #(
    .H_PIXELS(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ROWS(16), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(0), .V_SYNC_POL(1),
    .HCW(HCW), .VCW(VCW), .COLOR_W(CW),
    .BORDER(2), .BLINK_FRAMES(2)
  ) dut (
    .pulse25M(clk),
    .reset(rst_n),
    .vif(vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] w;
    logic [4:0] h;
    logic [5:0] fg;
    logic       rev;
    int         hp;
    int         vp;
    logic [2:0] svv;   // {h_sync, v_sync, visible}
    logic [5:0] rgb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] w, input logic [4:0] h, input logic [5:0] fg,
                              input logic rev, input int hp, input int vp,
                              input logic [2:0] svv, input logic [5:0] rgb);
    vec_t v;
    v.w = w; v.h = h; v.fg = fg; v.rev = rev;
    v.hp = hp; v.vp = vp; v.svv = svv; v.rgb = rgb;
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {vif.frame_start, vif.h_sync, vif.v_sync, vif.visible, vif.red, vif.green, vif.blue};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [5:0] w, input logic [4:0] h, input logic [5:0] fg,
                         input logic rev, input logic fl, input logic tm);
    vif.width = w; vif.height = h; vif.fg_rgb = fg;
    vif.rev = rev; vif.fl = fl; vif.test_mode = tm;
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vif.frame_start && n < 2 * FRAME);
    if (!vif.frame_start) begin
      n_vec++;
      n_bad++;
      $display("FAIL sync_frame: no frame_start within %0d cycles", 2 * FRAME);
    end
    pos = 0;
  endtask

  task automatic goto_pos(input int k);
    while (pos < k) begin
      @(negedge clk);
      pos++;
    end
  endtask

  logic [1:0] blink_exp [5];
  int hs_n, vs_n;

  initial begin
    // Expected rgb codes: 6'h36 = {3,1,2}, 6'h3F = all ones, 6'h09 = {0,2,1}.
    // Config A: w=10 h=6 -> inner x[11,21) y[5,11), grown x[9,23) y[3,13).
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0,  0,  0, 3'b100, 6'h00));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0,  3,  0, 3'b000, 6'h00));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0,  0,  2, 3'b110, 6'h00));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 17,  7, 3'b101, 6'h36));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 18, 12, 3'b101, 6'h36));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 19, 12, 3'b101, 6'h00));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 28,  9, 3'b101, 6'h00));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 29,  9, 3'b101, 6'h36));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 30, 16, 3'b101, 6'h36));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 31, 12, 3'b101, 6'h00));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 23, 17, 3'b101, 6'h00));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b0, 16, 12, 3'b101, 6'h00));
    // Config A with rev: background all ones, border inverted, blanking 0.
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b1,  8,  4, 3'b101, 6'h3F));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b1, 17,  7, 3'b101, 6'h09));
    vecs.push_back(mk(6'd10, 5'd6, 6'h36, 1'b1,  7,  4, 3'b100, 6'h00));
    // Odd size w=7 h=5 -> inner x[13,19) y[6,10), grown x[11,21) y[4,12).
    vecs.push_back(mk(6'd7, 5'd5, 6'h3F, 1'b0, 20, 10, 3'b101, 6'h3F));
    vecs.push_back(mk(6'd7, 5'd5, 6'h3F, 1'b0, 21, 10, 3'b101, 6'h00));
    vecs.push_back(mk(6'd7, 5'd5, 6'h3F, 1'b0, 27, 13, 3'b101, 6'h3F));
    vecs.push_back(mk(6'd7, 5'd5, 6'h3F, 1'b0, 29, 13, 3'b101, 6'h00));
    vecs.push_back(mk(6'd7, 5'd5, 6'h3F, 1'b0, 24, 15, 3'b101, 6'h3F));
    // Oversized width, zero height -> no border anywhere.
    vecs.push_back(mk(6'd63, 5'd0, 6'h3F, 1'b0,  8,  4, 3'b101, 6'h00));
    vecs.push_back(mk(6'd63, 5'd0, 6'h3F, 1'b0, 24, 12, 3'b101, 6'h00));
    // Full-screen box -> border clipped away.
    vecs.push_back(mk(6'd32, 5'd16, 6'h3F, 1'b0,  8,  4, 3'b101, 6'h00));
    vecs.push_back(mk(6'd32, 5'd16, 6'h3F, 1'b0, 39, 19, 3'b101, 6'h00));
    // w clamps to 32, h=10 -> border only on rows y=1,2,13,14.
    vecs.push_back(mk(6'd40, 5'd10, 6'h3F, 1'b0,  8,  5, 3'b101, 6'h3F));
    vecs.push_back(mk(6'd40, 5'd10, 6'h3F, 1'b0, 39, 18, 3'b101, 6'h3F));
    vecs.push_back(mk(6'd40, 5'd10, 6'h3F, 1'b0,  8,  4, 3'b101, 6'h00));
    vecs.push_back(mk(6'd40, 5'd10, 6'h3F, 1'b0, 13,  9, 3'b101, 6'h00));
    // 1x1 -> empty inner box, full 4x4 border block at x[14,18) y[6,10).
    vecs.push_back(mk(6'd1, 5'd1, 6'h3F, 1'b0, 24, 12, 3'b101, 6'h3F));
    vecs.push_back(mk(6'd1, 5'd1, 6'h3F, 1'b0, 26, 12, 3'b101, 6'h00));

    blink_exp = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd3};

    // Reset state
    set_cfg(6'd0, 5'd0, 6'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_state", outs(), 10'b0100000000);

    // First edge after release renders h=0,v=0
    rst_n = 1'b1;
    @(negedge clk);
    check("first_frame_start", outs(), 10'b1100000000);

    // Sync pulse widths over one whole frame
    pos = 0;
    hs_n = 0;
    vs_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) begin
        @(negedge clk);
        pos++;
      end
      if (vif.h_sync == 1'b0) hs_n++;
      if (vif.v_sync == 1'b1) vs_n++;
    end
    check_int("h_sync_active_cycles", hs_n, 4 * 20);
    check_int("v_sync_active_cycles", vs_n, 2 * 40);

    // Table-driven vectors: each config takes effect at the next frame
    foreach (vecs[i]) begin
      set_cfg(vecs[i].w, vecs[i].h, vecs[i].fg, vecs[i].rev, 1'b0, 1'b0);
      sync_frame();
      goto_pos(vecs[i].hp + vecs[i].vp * H_TOTAL);
      check($sformatf("vec[%0d] h=%0d v=%0d", i, vecs[i].hp, vecs[i].vp), outs(),
            {(vecs[i].hp == 0 && vecs[i].vp == 0), vecs[i].svv, vecs[i].rgb});
    end

    // Mid-frame width change waits for the next frame
    set_cfg(6'd10, 5'd6, 6'h36, 1'b0, 1'b0, 1'b0);
    sync_frame();
    goto_pos(240);
    vif.width = 6'd20;
    goto_pos(493);
    check("midframe_old_width", outs(), 10'b0101000000);
    sync_frame();
    goto_pos(493);
    check("midframe_new_width", outs(), {4'b0101, 6'h36});

    // Blink with BLINK_FRAMES=2, counted from a fresh reset
    set_cfg(6'd10, 5'd6, 6'h3F, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      sync_frame();
      goto_pos(297);
      check($sformatf("blink_frame%0d", n), outs(), {4'b0101, blink_exp[n], blink_exp[n], blink_exp[n]});
    end
    vif.rev = 1'b1;
    sync_frame();
    goto_pos(168);
    check("rev_background", outs(), {4'b0101, 6'h3F});
    goto_pos(297);
    check("rev_border_phase0", outs(), {4'b0101, 6'h00});
    sync_frame();
    goto_pos(297);
    check("rev_border_phase1", outs(), {4'b0101, 6'h3F});

    // One-cycle reset in the middle of a line
    set_cfg(6'd10, 5'd6, 6'h36, 1'b0, 1'b0, 1'b0);
    sync_frame();
    goto_pos(50);
    rst_n = 1'b0;
    @(negedge clk);
    check("midline_reset_outputs", outs(), 10'b0100000000);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_frame_start", outs(), 10'b1100000000);
    pos = 0;
    goto_pos(3);
    check("restart_h3", outs(), 10'b0000000000);
    goto_pos(47);
    check("restart_h7_v1", outs(), 10'b0110000000);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars, 4 pixels wide; border suppressed
    set_cfg(6'd10, 5'd6, 6'h3F, 1'b0, 1'b0, 1'b1);
    sync_frame();
    goto_pos(297);
    check("bar2_over_border", outs(), {4'b0101, 6'h0C});
    goto_pos(516);
    check("bar7", outs(), {4'b0101, 6'h3F});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
